// File: rtl/mc_tag_lookup.sv
// mc_tag_lookup: lookup/update engine for N_WAYS tag RAMs that share one set index.
// Takes one access at a time (idx, tag, write). It reads all ways, reports hit/miss
// and the LRU victim, and writes back the per-set LRU ages.
// On a miss the new tag is committed only when the line fill completes.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_*                     request handshake (req_ready high only in IDLE)
//   rsp_*                     one-cycle result pulse: hit/way and victim info
//   fill_done / fill_abort    miss resolution from the line-fill side
//   tr_r_*                    tag RAM read port (data returns 1 cycle after tr_r_ena)
//   tr_w_*                    tag RAM write port with per-way, per-field write enables
module mc_tag_lookup #(
    parameter int unsigned IDX_WIDTH = 8,
    parameter int unsigned TAG_WIDTH = 12,
    parameter int unsigned AGE_WIDTH = 2,
    parameter int unsigned N_WAYS    = 4,
    localparam int unsigned WAY_W    = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [IDX_WIDTH-1:0]          req_idx,
    input  logic [TAG_WIDTH-1:0]          req_tag,
    input  logic                          req_write,
    output logic                          rsp_valid,
    output logic                          rsp_hit,
    output logic [WAY_W-1:0]              rsp_way,
    output logic                          rsp_vic_valid,
    output logic                          rsp_vic_dirty,
    output logic [TAG_WIDTH-1:0]          rsp_vic_tag,
    input  logic                          fill_done,
    input  logic                          fill_abort,
    output logic [IDX_WIDTH-1:0]          tr_r_idx,
    output logic                          tr_r_ena,
    input  logic [N_WAYS-1:0]             tr_r_valid,
    input  logic [N_WAYS-1:0]             tr_r_dirty,
    input  logic [N_WAYS*AGE_WIDTH-1:0]   tr_r_age,
    input  logic [N_WAYS*TAG_WIDTH-1:0]   tr_r_tag,
    output logic [IDX_WIDTH-1:0]          tr_w_idx,
    output logic [N_WAYS-1:0]             tr_w_ena,
    output logic [N_WAYS-1:0]             tr_w_valid_we,
    output logic                          tr_w_valid,
    output logic [N_WAYS-1:0]             tr_w_dirty_we,
    output logic                          tr_w_dirty,
    output logic [N_WAYS-1:0]             tr_w_age_we,
    output logic [N_WAYS*AGE_WIDTH-1:0]   tr_w_age,
    output logic [N_WAYS-1:0]             tr_w_tag_we,
    output logic [TAG_WIDTH-1:0]          tr_w_tag
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

    logic [1:0]                  state_q, state_d;
    logic [IDX_WIDTH-1:0]        idx_q, idx_d;
    logic [TAG_WIDTH-1:0]        tag_q, tag_d;
    logic                        write_q, write_d;
    logic                        hit_q, hit_d;
    logic [WAY_W-1:0]            way_q, way_d;
    logic                        vic_valid_q, vic_valid_d;
    logic                        vic_dirty_q, vic_dirty_d;
    logic [TAG_WIDTH-1:0]        vic_tag_q, vic_tag_d;
    logic [N_WAYS*AGE_WIDTH-1:0] ages_q, ages_d;

    logic                        cmp_hit, hit_found, inv_found;
    logic [WAY_W-1:0]            cmp_way, hit_way, inv_way, max_way;
    logic [AGE_WIDTH-1:0]        max_age, acc_age, age_w;
    logic                        cmp_vic_valid, cmp_vic_dirty;
    logic [TAG_WIDTH-1:0]        cmp_vic_tag;
    logic [N_WAYS*AGE_WIDTH-1:0] cmp_ages;
    logic [N_WAYS-1:0]           way_onehot;

    // Tag compare, victim choice and next LRU ages from the RAM read data.
    always_comb begin
        hit_found     = 1'b0;
        inv_found     = 1'b0;
        hit_way       = '0;
        inv_way       = '0;
        max_way       = '0;
        max_age       = '0;
        acc_age       = '0;
        age_w         = '0;
        cmp_vic_valid = 1'b0;
        cmp_vic_dirty = 1'b0;
        cmp_vic_tag   = '0;
        cmp_ages      = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            age_w = tr_r_age[w*AGE_WIDTH +: AGE_WIDTH];
            if (!hit_found && tr_r_valid[w] && (tr_r_tag[w*TAG_WIDTH +: TAG_WIDTH] == tag_q)) begin
                hit_found = 1'b1;
                hit_way   = WAY_W'(w);
            end
            if (!inv_found && !tr_r_valid[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            // strict compare keeps the lowest index among equal maximum ages
            if (age_w > max_age) begin
                max_age = age_w;
                max_way = WAY_W'(w);
            end
        end
        cmp_hit = hit_found;
        cmp_way = hit_found ? hit_way : (inv_found ? inv_way : max_way);
        for (int w = 0; w < N_WAYS; w++) begin
            if (WAY_W'(w) == cmp_way) begin
                acc_age       = tr_r_age[w*AGE_WIDTH +: AGE_WIDTH];
                cmp_vic_valid = tr_r_valid[w];
                cmp_vic_dirty = tr_r_dirty[w];
                cmp_vic_tag   = tr_r_tag[w*TAG_WIDTH +: TAG_WIDTH];
            end
        end
        // accessed way becomes youngest; ways younger than it age by one
        for (int w = 0; w < N_WAYS; w++) begin
            age_w = tr_r_age[w*AGE_WIDTH +: AGE_WIDTH];
            if (WAY_W'(w) == cmp_way) begin
                cmp_ages[w*AGE_WIDTH +: AGE_WIDTH] = '0;
            end else if (age_w < acc_age) begin
                cmp_ages[w*AGE_WIDTH +: AGE_WIDTH] = (age_w == AGE_MAX) ? age_w : age_w + AGE_WIDTH'(1);
            end else begin
                cmp_ages[w*AGE_WIDTH +: AGE_WIDTH] = age_w;
            end
        end
    end

    assign way_onehot = N_WAYS'(1) << way_q;

    // Next-state, capture and tag RAM write strobes.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        tag_d         = tag_q;
        write_d       = write_q;
        hit_d         = hit_q;
        way_d         = way_q;
        vic_valid_d   = vic_valid_q;
        vic_dirty_d   = vic_dirty_q;
        vic_tag_d     = vic_tag_q;
        ages_d        = ages_q;
        tr_w_ena      = '0;
        tr_w_valid_we = '0;
        tr_w_valid    = 1'b0;
        tr_w_dirty_we = '0;
        tr_w_dirty    = 1'b0;
        tr_w_age_we   = '0;
        tr_w_age      = '0;
        tr_w_tag_we   = '0;
        tr_w_tag      = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    idx_d   = req_idx;
                    tag_d   = req_tag;
                    write_d = req_write;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                hit_d       = cmp_hit;
                way_d       = cmp_way;
                vic_valid_d = cmp_vic_valid;
                vic_dirty_d = cmp_vic_dirty;
                vic_tag_d   = cmp_vic_tag;
                ages_d      = cmp_ages;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (hit_q) begin
                    tr_w_ena    = '1;
                    tr_w_age_we = '1;
                    tr_w_age    = ages_q;
                    if (write_q) begin
                        tr_w_dirty_we = way_onehot;
                        tr_w_dirty    = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // fill_done takes priority when both arrive together
                if (fill_done) begin
                    tr_w_ena      = '1;
                    tr_w_age_we   = '1;
                    tr_w_age      = ages_q;
                    tr_w_valid_we = way_onehot;
                    tr_w_valid    = 1'b1;
                    tr_w_dirty_we = way_onehot;
                    tr_w_dirty    = write_q;
                    tr_w_tag_we   = way_onehot;
                    tr_w_tag      = tag_q;
                    state_d       = ST_IDLE;
                end else if (fill_abort) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tag_q       <= '0;
            write_q     <= 1'b0;
            hit_q       <= 1'b0;
            way_q       <= '0;
            vic_valid_q <= 1'b0;
            vic_dirty_q <= 1'b0;
            vic_tag_q   <= '0;
            ages_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tag_q       <= tag_d;
            write_q     <= write_d;
            hit_q       <= hit_d;
            way_q       <= way_d;
            vic_valid_q <= vic_valid_d;
            vic_dirty_q <= vic_dirty_d;
            vic_tag_q   <= vic_tag_d;
            ages_q      <= ages_d;
        end
    end

    // Reads are launched straight from the request so data lands in CMP.
    assign req_ready     = (state_q == ST_IDLE);
    assign tr_r_ena      = (state_q == ST_IDLE) && req_valid;
    assign tr_r_idx      = req_idx;
    assign tr_w_idx      = idx_q;
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_hit       = hit_q;
    assign rsp_way       = way_q;
    assign rsp_vic_valid = vic_valid_q;
    assign rsp_vic_dirty = vic_dirty_q;
    assign rsp_vic_tag   = vic_tag_q;

endmodule
